// File: rtl/imem_line_buffer_pkg.sv
// ----------------------------------------------------------------------------
// imem_line_buffer_pkg
// Shared definitions for the instruction-fetch line buffer and the memory-side
// blocks that talk to it: line geometry, tag width and the controller states.
// ----------------------------------------------------------------------------
package imem_line_buffer_pkg;

    localparam int BURST_BEATS = 4;                     // 64-bit beats per line
    localparam int BEAT_W      = 64;
    localparam int WORD_W      = 32;
    localparam int LINE_W      = BURST_BEATS * BEAT_W;  // 256-bit line
    localparam int OFFSET_W    = 5;                     // byte offset in a line
    localparam int TAG_W       = 32 - OFFSET_W;         // addr[31:5]

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Line-aligned burst address for a fetch address.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/imem_line_buffer_if.sv
// ----------------------------------------------------------------------------
// imem_line_buffer_if
// Bundles the fetch-side request/response signals and the burst-memory side
// signals of the line buffer.
//   slave  : the line buffer's view (receives fetch requests and beats)
//   master : the environment's view (issues fetches, serves bursts)
// ----------------------------------------------------------------------------
interface imem_line_buffer_if;
    import imem_line_buffer_pkg::*;

    logic [31:0]       imem_addr;
    logic [3:0]        imem_rmask;
    logic [WORD_W-1:0] imem_rdata;
    logic              imem_resp;
    logic              flush;
    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_resp;

    modport slave (
        input  imem_addr, imem_rmask, flush, bmem_rdata, bmem_resp,
        output imem_rdata, imem_resp, bmem_addr, bmem_read
    );

    modport master (
        output imem_addr, imem_rmask, flush, bmem_rdata, bmem_resp,
        input  imem_rdata, imem_resp, bmem_addr, bmem_read
    );

endinterface

// File: rtl/imem_line_store.sv
// ----------------------------------------------------------------------------
// imem_line_store
// One 256-bit line held as four 64-bit beat registers. A beat write replaces
// one slot; the 32-bit read port selects a word combinationally.
//   clk, rst   : clock, asynchronous active-low reset (clears the line)
//   wr_en      : write wr_data into slot wr_beat
//   rd_word    : word index within the line (bits [2:1] beat, bit [0] half)
//   rd_data    : selected 32-bit word
// ----------------------------------------------------------------------------
module imem_line_store
    import imem_line_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_beat,
    input  logic [BEAT_W-1:0] wr_data,
    input  logic [2:0]        rd_word,
    output logic [WORD_W-1:0] rd_data
);

    logic [BEAT_W-1:0] line_w [BURST_BEATS];
    logic [BEAT_W-1:0] rd_beat;

    genvar gi;
    generate
        for (gi = 0; gi < BURST_BEATS; gi++) begin : g_beat
            logic [BEAT_W-1:0] beat_q;
            logic [BEAT_W-1:0] beat_d;

            always_comb begin
                beat_d = beat_q;
                if (wr_en && (wr_beat == 2'(gi))) begin
                    beat_d = wr_data;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    beat_q <= '0;
                end else begin
                    beat_q <= beat_d;
                end
            end

            assign line_w[gi] = beat_q;
        end
    endgenerate

    always_comb begin
        rd_beat = line_w[rd_word[2:1]];
        rd_data = rd_word[0] ? rd_beat[63:32] : rd_beat[31:0];
    end

endmodule

// File: rtl/imem_line_buffer.sv
// ----------------------------------------------------------------------------
// imem_line_buffer
// Single-line instruction buffer. A fetch that hits the held line answers the
// following cycle; a miss fetches the whole 32-byte line with one burst read
// (four 64-bit beats) and answers one cycle after the last beat. A flush
// cancels the outstanding answer but never the line fill itself.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : fetch port (imem_*, flush) and burst-memory port (bmem_*)
// ----------------------------------------------------------------------------
module imem_line_buffer #(
    parameter int BURST_BEATS = imem_line_buffer_pkg::BURST_BEATS
) (
    input  logic               clk,
    input  logic               rst,
    imem_line_buffer_if.slave  bus
);
    import imem_line_buffer_pkg::*;

    localparam int BEAT_CNT_W = $clog2(BURST_BEATS);

    state_e                  state_q,     state_d;
    logic [31:2]             addr_q,      addr_d;
    logic [TAG_W-1:0]        tag_q,       tag_d;
    logic                    valid_q,     valid_d;
    logic                    hit_pend_q,  hit_pend_d;
    logic                    cancel_q,    cancel_d;
    logic                    bmem_read_q, bmem_read_d;
    logic [31:0]             bmem_addr_q, bmem_addr_d;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;

    logic                    req;
    logic                    hit;
    logic                    last_beat;
    logic                    line_wr_en;
    logic                    resp_raw;
    logic [WORD_W-1:0]       line_word;
    logic                    unused_addr_lsbs;

    // Byte lane bits play no part in word selection.
    assign unused_addr_lsbs = ^bus.imem_addr[1:0];

    assign req       = |bus.imem_rmask;
    assign hit       = valid_q && (tag_q == bus.imem_addr[31:OFFSET_W]);
    assign last_beat = (beat_cnt_q == BEAT_CNT_W'(BURST_BEATS - 1));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        hit_pend_d  = 1'b0;
        cancel_d    = cancel_q;
        bmem_read_d = 1'b0;
        bmem_addr_d = bmem_addr_q;
        beat_cnt_d  = beat_cnt_q;
        line_wr_en  = 1'b0;

        case (state_q)
            // RESP behaves like IDLE for new requests so that back-to-back
            // fetches are accepted in the response cycle.
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (req) begin
                    addr_d   = bus.imem_addr[31:2];
                    cancel_d = 1'b0;
                    if (hit) begin
                        hit_pend_d = 1'b1;
                    end else begin
                        valid_d     = 1'b0;
                        bmem_read_d = 1'b1;
                        bmem_addr_d = line_base(bus.imem_addr);
                        state_d     = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (bus.flush) begin
                    cancel_d = 1'b1;
                end
                state_d = ST_BURST;
            end

            ST_BURST: begin
                if (bus.flush) begin
                    cancel_d = 1'b1;
                end
                if (bus.bmem_resp) begin
                    line_wr_en = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat) begin
                        valid_d = 1'b1;
                        tag_d   = addr_q[31:OFFSET_W];
                        // A flush seen anywhere during the fill, including
                        // this last beat, drops the answer.
                        state_d = (cancel_q || bus.flush) ? ST_IDLE : ST_RESP;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            tag_q       <= '0;
            valid_q     <= 1'b0;
            hit_pend_q  <= 1'b0;
            cancel_q    <= 1'b0;
            bmem_read_q <= 1'b0;
            bmem_addr_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            hit_pend_q  <= hit_pend_d;
            cancel_q    <= cancel_d;
            bmem_read_q <= bmem_read_d;
            bmem_addr_q <= bmem_addr_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    imem_line_store u_line_store (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (line_wr_en),
        .wr_beat (beat_cnt_q),
        .wr_data (bus.bmem_rdata),
        .rd_word (addr_q[4:2]),
        .rd_data (line_word)
    );

    // The response is gated by flush in its own cycle, so a mispredict that
    // arrives as the answer goes out still suppresses it.
    assign resp_raw       = (state_q == ST_RESP) || hit_pend_q;
    assign bus.imem_resp  = resp_raw && !bus.flush;
    assign bus.imem_rdata = bus.imem_resp ? line_word : '0;
    assign bus.bmem_read  = bmem_read_q;
    assign bus.bmem_addr  = bmem_addr_q;

endmodule

// File: doc/imem_line_buffer.md
IMEM_LINE_BUFFER -- requirements
Module: imem_line_buffer

Interface
REQ-001 Parameter: BURST_BEATS, default 4, number of 64-bit beats per 32-byte line (fixed at 4 in this revision).
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 imem_addr  input  32  fetch byte address, sampled when imem_rmask != 0.
REQ-005 imem_rmask  input  4  nonzero for exactly one cycle = read request.
REQ-006 imem_rdata  output  32  instruction word, valid only while imem_resp=1.
REQ-007 imem_resp  output  1  one-cycle response pulse.
REQ-008 flush  input  1  branch mispredict; cancels delivery of the outstanding response.
REQ-009 bmem_addr  output  32  line-aligned burst address.
REQ-010 bmem_read  output  1  one-cycle burst read request.
REQ-011 bmem_rdata  input  64  burst beat data.
REQ-012 bmem_resp  input  1  beat valid; beats arrive in ascending address order.

Function
REQ-013 The block SHALL hold one 256-bit line, a 27-bit tag (addr[31:5]) and a valid bit.
REQ-014 FSM states SHALL be IDLE, REQ, BURST, RESP.
REQ-015 IDLE + request + hit (valid and tag match) SHALL latch the address, stay IDLE, and assert imem_resp the next cycle with imem_rdata = line word addr[4:2].
REQ-016 IDLE + request + miss SHALL latch the address, clear valid, and go to REQ.
REQ-017 REQ SHALL assert bmem_read for exactly one cycle with bmem_addr = {addr[31:5],5'b0}, then go to BURST.
REQ-018 BURST SHALL write each bmem_resp beat into line slot beat_cnt (2-bit counter, reset 0) and increment the counter, wrapping 3->0.
REQ-019 On the 4th beat the block SHALL set valid, load the tag, and go to RESP.
REQ-020 RESP SHALL assert imem_resp for one cycle with the requested word, then go to IDLE.
REQ-021 Miss latency SHALL be request cycle + 1 (REQ) + beat cycles + 1 (RESP).
REQ-022 bmem_addr SHALL be held stable from the bmem_read cycle until the last beat.
REQ-023 imem_addr[1:0] SHALL be ignored; word selection uses addr[4:2] only (addr[4:3] = beat, addr[2] = half).
REQ-024 A request with imem_rmask != 0 while not in IDLE and not coincident with imem_resp SHALL be ignored.
REQ-025 A request in the same cycle as imem_resp SHALL be accepted as a new request (back-to-back).
REQ-026 flush while in REQ or BURST SHALL let the burst complete and fill the line, but suppress the RESP pulse (return to IDLE instead).
REQ-027 flush in the cycle a hit response or the RESP pulse would issue SHALL force imem_resp to 0.
REQ-028 flush coincident with a new request SHALL accept the request; only the older response is cancelled.
REQ-029 bmem_resp outside BURST SHALL be ignored.
REQ-030 imem_rdata SHALL be 0 when imem_resp=0.

Reset
REQ-031 rst=0 SHALL asynchronously force state IDLE, valid=0, beat_cnt=0, a pending-hit flag of 0, imem_resp=0, imem_rdata=0, bmem_read=0 and bmem_addr=0.
REQ-032 Reset mid-burst SHALL abandon the burst; post-reset beats SHALL be ignored per REQ-029.

Structure
REQ-033 The FSM state enum, the line/tag widths and BURST_BEATS SHALL live in the shared package used by the fetch and memory-side blocks.
REQ-034 One sub-module, imem_line_store (256-bit line register with beat write and word read), is natural; the FSM stays in the top.

Verification
REQ-035 Cold miss: request 0x6000_0004 -> one bmem_read with addr 0x6000_0000; beats 0x11..,0x22..,0x33..,0x44.. -> imem_resp one cycle after the 4th beat with rdata = upper half of beat 0.
REQ-036 Hit: after the REQ-035 fill, request 0x6000_001C -> imem_resp the next cycle, rdata = upper half of beat 3, no bmem_read.
REQ-037 Back-to-back hits: requests 0x6000_0000 and 0x6000_0008 on consecutive resp cycles -> two consecutive resp pulses, correct words.
REQ-038 Flush mid-burst: flush in beat 2 -> no imem_resp; a following request 0x6000_0010 hits in 1 cycle.
REQ-039 Beat gaps: bmem_resp low for 3 cycles between beats -> same data and a single resp; a request issued while busy is ignored.
REQ-040 Reset mid-burst: rst=0 after beat 1 -> all outputs 0 immediately; re-request 0x6000_0000 -> fresh bmem_read.
